mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store sequencer between the MIPS MEM-stage datapath and the word-only data RAM (10-bit word address, 32-bit data, write-first, 1-cycle registered read).
- Implements lb/lbu/lh/lhu/lw/sb/sh/sw on byte addresses.
- The RAM has no byte enables, so sub-word stores use a read-modify-write sequence.
- Big-endian: byte offset 0 maps to bits 31:24.

Parameters:
- RAM_AW, 10, RAM word-address width; byte address bits [RAM_AW+1:2] select the word.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  sign-extend a sub-word load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, extended to 32 bits.
- resp_err  out  1  request rejected; valid with resp_valid.
- ram_we  out  1  RAM write enable.
- ram_addr  out  RAM_AW  RAM word address.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data, valid the cycle after the address is presented.

Behaviour:
- States: IDLE, RD, WR, MRG, LD, DONE. State and request registers are asynchronously reset.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, ram_we=0, ram_addr=0, ram_din=0.
- req_ready = (state==IDLE). A request is accepted on a rising edge with req_valid && req_ready; addr, size, we, signed and wdata are registered.
- ram_addr is driven from the registered addr[RAM_AW+1:2].
- ram_we is decoded combinationally from state (WR or MRG), so asserting rst_n=0 drops ram_we immediately.
- Error check at accept: size 11, half with addr[0]=1, or word with addr[1:0]!=0. On error: IDLE→DONE with resp_err=1, resp_rdata=0, no RAM access. Latency 1 from accept.
- Word store: IDLE→WR (ram_we=1, ram_din=wdata)→DONE. resp_valid 2 cycles after accept.
- Sub-word store: IDLE→RD (ram_we=0)→MRG→DONE. In MRG, ram_we=1 and ram_din = ram_dout with the target lane replaced by wdata[7:0] or wdata[15:0]. resp_valid 3 cycles after accept.
- Store lane positions: byte offset k occupies bits [31-8k:24-8k]; half offset 0 is [31:16], offset 2 is [15:0].
- Load: IDLE→RD→LD→DONE. In LD, the lane is extracted from ram_dout, zero- or sign-extended per req_signed (ignored for word), and registered into resp_rdata. resp_valid 3 cycles after accept.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata and resp_err hold their values until the next response.
- No response backpressure. Maximum rate is one request per (latency+1) cycles.
- ram_we is high for exactly one cycle per successful store and never for loads or errors.
- Stores resp_rdata=0.
- Address bits above RAM_AW+1 are ignored (aliasing) unless the optional feature is enabled.
- Reset mid-operation: return to IDLE, abort any pending write, emit no response. A word already written in WR/MRG before reset keeps its value.

Optional Feature:
- MEM_ACCESS_RANGE_CHECK_EN defined: a nonzero req_addr[31:RAM_AW+2] is an additional error condition, handled like misalignment (latency 1, no RAM access).
- Undefined: upper address bits are ignored and addresses alias modulo 4*2^RAM_AW bytes.

Test Plan:
- Preload word 4 = 0x11223344; sb addr 0x11 wdata 0x000000AA → word 4 = 0x11AA3344; ram_we high exactly 1 cycle; resp_valid 3 cycles after accept; resp_err=0.
- After the above: lb signed addr 0x11 → resp_rdata 0xFFFFFFAA; lbu addr 0x11 → 0x000000AA; lw addr 0x10 → 0x11AA3344 at latency 3.
- sh addr 0x10 wdata 0x00008001 → word 4 = 0x80013344; lh signed 0x10 → 0xFFFF8001; lhu 0x12 → 0x00003344.
- lw addr 0x13, sh addr 0x11, size 11 → each gives resp_err=1, resp_rdata=0, latency 1, ram_we never asserted, RAM unchanged.
- sb addr 0x12 with rst_n driven low during the MRG cycle → ram_we falls with rst_n; word 4 unchanged; no resp_valid; req_ready=1 after release; next lw returns the old value.
- lw addr 0x00001010: with MEM_ACCESS_RANGE_CHECK_EN → resp_err=1; without → returns word 4 contents.

Source files
------------

// File: rtl/mem_access_unit.sv
// Purpose : load/store sequencer between the MEM-stage datapath and a word-only data RAM.
// Latency : 1 cycle for rejected requests, 2 for word stores, 3 for loads and sub-word stores.
// Backpressure: req_ready only in IDLE; responses are one-cycle pulses with no backpressure.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_we, req_size, req_signed    store/load, size (00 b, 01 h, 10 w, 11 illegal), sign-extend
//   req_addr, req_wdata             byte address, right-aligned store data
//   resp_valid, resp_rdata, resp_err  completion pulse, extended load data, reject flag
//   ram_we, ram_addr, ram_din, ram_dout  word RAM (write-first, 1-cycle registered read)
//
// Optional feature macro: MEM_ACCESS_RANGE_CHECK_EN
//   defined   -> nonzero req_addr[31:RAM_AW+2] is rejected like a misaligned access
//   undefined -> upper address bits are ignored (addresses alias)
//
// Big-endian lanes: byte offset 0 is bits [31:24].

module mem_access_unit #(
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    MRG  = 3'd3,
    LD   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t              state;
  logic [RAM_AW+1:0]   addr_q;
  logic [1:0]          size_q;
  logic                we_q;
  logic                signed_q;
  logic [31:0]         wdata_q;

  logic                req_err;
  logic [4:0]          lane_sh;
  logic [31:0]         lane_mask;
  logic [15:0]         lane;
  logic [31:0]         merged;
  logic [31:0]         load_val;

  // Request validity, evaluated on the live request at accept time.
  always_comb begin
    req_err = (req_size == 2'b11) ||
              (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`ifdef MEM_ACCESS_RANGE_CHECK_EN
    if (req_addr[31:RAM_AW+2] != '0) req_err = 1'b1;
`endif
  end

`ifndef MEM_ACCESS_RANGE_CHECK_EN
  // Upper address bits deliberately dropped: addresses alias modulo the RAM size.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:RAM_AW+2];
`endif

  // Right-shift that brings the addressed lane down to bit 0 (big-endian):
  // byte offset k -> 8*(3-k), half offset 0 -> 16, offset 2 -> 0.
  always_comb begin
    lane_sh   = 5'd0;
    lane_mask = 32'hFFFF_FFFF;
    case (size_q)
      2'b00: begin
        lane_sh   = {~addr_q[1:0], 3'b000};
        lane_mask = 32'h0000_00FF << lane_sh;
      end
      2'b01: begin
        lane_sh   = {~addr_q[1], 4'b0000};
        lane_mask = 32'h0000_FFFF << lane_sh;
      end
      default: begin
        lane_sh   = 5'd0;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign lane   = 16'(ram_dout >> lane_sh);
  assign merged = (ram_dout & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);

  always_comb begin
    case (size_q)
      2'b00:   load_val = signed_q ? {{24{lane[7]}}, lane[7:0]} : {24'h0, lane[7:0]};
      2'b01:   load_val = signed_q ? {{16{lane[15]}}, lane} : {16'h0, lane};
      default: load_val = ram_dout;
    endcase
  end

  // Write strobe straight from state so an async reset kills a pending write at once.
  assign ram_we    = (state == WR) || (state == MRG);
  assign ram_addr  = addr_q[RAM_AW+1:2];
  assign ram_din   = (state == WR)  ? wdata_q :
                     (state == MRG) ? merged  : 32'h0;
  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      size_q     <= 2'b00;
      we_q       <= 1'b0;
      signed_q   <= 1'b0;
      wdata_q    <= 32'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr[RAM_AW+1:0];
            size_q   <= req_size;
            we_q     <= req_we;
            signed_q <= req_signed;
            wdata_q  <= req_wdata;
            if (req_err) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (req_we && req_size == 2'b10) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD:  state <= we_q ? MRG : LD;
        WR, MRG: begin
          state      <= DONE;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end
        LD: begin
          state      <= DONE;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= load_val;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: scoreboard queue filled by the driver, drained by a monitor.
// Reference model works on byte arrays of a shadow memory, independent of the RTL datapath.
// A plain behavioural word RAM (write-first, registered read) sits on the RAM port.

module tb_mem_access_unit;

  localparam int AW    = 10;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_signed = 1'b0;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout = 32'h0;

  mem_access_unit #(.RAM_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [WORDS];
  logic [31:0] ref_mem [WORDS];

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram_we ? ram_din : ram[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
    int          nwe;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails  = 0;
  int we_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: decide outcome and update shadow memory from byte-level rules.
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rdata, output logic err,
                       output int lat, output int nwe);
    int w, k;
    logic [7:0] b [4];
    logic [31:0] v;
    w = int'((addr / 4) % WORDS);
    k = int'(addr % 4);
    err = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
          (size == 2'd2 && (addr % 4) != 0);
`ifdef MEM_ACCESS_RANGE_CHECK_EN
    if (addr >= 32'(4 * WORDS)) err = 1'b1;
`endif
    for (int i = 0; i < 4; i++) b[i] = 8'(ref_mem[w] >> (24 - 8 * i));
    rdata = 32'h0;
    nwe   = 0;
    lat   = 1;
    if (err) return;
    if (we) begin
      if (size == 2'd0) b[k] = wd[7:0];
      else if (size == 2'd1) begin b[k] = wd[15:8]; b[k+1] = wd[7:0]; end
      else begin b[0] = wd[31:24]; b[1] = wd[23:16]; b[2] = wd[15:8]; b[3] = wd[7:0]; end
      ref_mem[w] = {b[0], b[1], b[2], b[3]};
      nwe = 1;
      lat = (size == 2'd2) ? 2 : 3;
    end else begin
      lat = 3;
      if (size == 2'd0) begin
        v = 32'(b[k]);
        if (sgn && b[k][7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
        v = 32'(b[k]) * 256 + 32'(b[k+1]);
        if (sgn && b[k][7]) v = v | 32'hFFFF_0000;
      end else begin
        v = {b[0], b[1], b[2], b[3]};
      end
      rdata = v;
    end
  endtask

  // Called at posedge+#1; returns after the request has been accepted.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int t = 0;
    int lat;
    while (!req_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (!req_ready) begin
      checks++; fails++;
      $display("FAIL ready_timeout actual=0 required=1");
      return;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    model(we, size, sgn, addr, wd, e.rdata, e.err, lat, e.nwe);
    e.due = cyc + lat - 1;
    q.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 50) begin @(posedge clk); #1; t++; end
    if (q.size() != 0) begin
      checks++; fails++;
      $display("FAIL resp_timeout actual=%0d pending required=0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Monitor: sample mid-cycle, pop and compare on every response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        we_cnt = 0;
      end else begin
        if (ram_we) we_cnt++;
        if (resp_valid) begin
          if (q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_resp actual=1 required=0 (t=%0t)", $time);
          end else begin
            e = q.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", 32'(resp_err), 32'(e.err));
            chk("resp_latency_cycle", 32'(cyc), 32'(e.due));
            chk("ram_we_cycles", 32'(we_cnt), 32'(e.nwe));
          end
          we_cnt = 0;
        end
      end
    end
  end

  initial begin
    int bad;
    logic [31:0] a;
    for (int i = 0; i < WORDS; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[4] = 32'h1122_3344;
    ref_mem[4] = 32'h1122_3344;

    #3;
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_din", ram_din, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed sequence
    issue(1, 2'd0, 0, 32'h11, 32'h0000_00AA); drain();
    chk("sb_word4", ram[4], 32'h11AA_3344);
    issue(0, 2'd0, 1, 32'h11, 32'h0);
    issue(0, 2'd0, 0, 32'h11, 32'h0);
    issue(0, 2'd2, 0, 32'h10, 32'h0);
    issue(1, 2'd1, 0, 32'h10, 32'h0000_8001);
    issue(0, 2'd1, 1, 32'h10, 32'h0);
    issue(0, 2'd1, 0, 32'h12, 32'h0);
    drain();
    chk("sh_word4", ram[4], 32'h8001_3344);
    issue(0, 2'd2, 0, 32'h13, 32'h0);
    issue(1, 2'd1, 0, 32'h11, 32'h1234_5678);
    issue(1, 2'd3, 0, 32'h10, 32'hDEAD_BEEF);
    issue(0, 2'd3, 1, 32'h10, 32'h0);
    drain();
    chk("err_word4", ram[4], 32'h8001_3344);

    // Reset during the merge cycle of a byte store
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h12; req_wdata = 32'h0000_0055;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    chk("mrg_ram_we", 32'(ram_we), 32'h1);
    chk("mrg_ram_din", ram_din, 32'h8001_5544);
    rst_n = 1'b0; #1;
    chk("abort_ram_we", 32'(ram_we), 32'h0);
    chk("abort_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    chk("abort_word4", ram[4], 32'h8001_3344);
    chk("post_rst_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    issue(0, 2'd2, 0, 32'h10, 32'h0);
    issue(0, 2'd2, 0, 32'h0000_1010, 32'h0);
    drain();

    // Randomized traffic over a small window with occasional upper-bit noise
    for (int n = 0; n < 400; n++) begin
      a = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) a = a | ($urandom << 12);
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();

    bad = 0;
    for (int i = 0; i < WORDS; i++) if (ram[i] !== ref_mem[i]) bad++;
    chk("final_ram_mismatch_words", 32'(bad), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
